// File: rtl/waveform_display_mc.sv
// Multi-channel scope trace renderer: flags, per pixel, which channel traces pass through (x,y).
// Supports per-channel vertical offset, power-of-two scaling and a vector mode joining adjacent columns.
module waveform_display_mc #(
  parameter int NCH       = 2,
  parameter int DATA_W    = 12,
  parameter int WIN_X0    = 20,
  parameter int WIN_X1    = 770,
  parameter int WIN_Y0    = 20,
  parameter int WIN_Y1    = 620,
  parameter int REFRESH_Y = 770,
  parameter int OFFS_STEP = 150,
  localparam int SEL_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NCH*DATA_W-1:0]   data,
  input  logic [NCH*2-1:0]        v_scaling,
  input  logic [NCH-1:0]          ch_en,
  input  logic [SEL_W-1:0]        sel_ch,
  input  logic                    up,
  input  logic                    down,
  input  logic                    vector_mode,
  input  logic [10:0]             x,
  input  logic [9:0]              y,
  output logic [NCH-1:0]          waveform_on,
  output logic                    any_on
);

  localparam int H  = 13;
  localparam int OW = 11;

  logic [OW-1:0] offset_q    [NCH];
  logic [OW-1:0] offset_d    [NCH];
  logic [H-1:0]  ndata       [NCH];
  logic [H-1:0]  cur_t       [NCH];
  logic [H-1:0]  cur_t_q     [NCH];
  logic [H-1:0]  prev_t_q    [NCH];
  logic [H-1:0]  prev_t_d    [NCH];
  logic [H-1:0]  seg_lo      [NCH];
  logic [H-1:0]  seg_hi      [NCH];
  logic [10:0]   x_q;
  logic          prev_valid_q;
  logic          prev_valid_d;
  logic          seen_q;
  logic          col_change;
  logic          in_win;
  logic          refresh;
  logic [H-1:0]  y_ext;
  logic [NCH-1:0] hit;
  logic [NCH-1:0] waveform_on_q;
  logic          any_on_q;

  assign col_change = (x != x_q);
  assign refresh    = (x == 11'd0) && (y == 10'(REFRESH_Y));
  assign y_ext      = {3'b000, y};
  assign in_win     = (x >= 11'(WIN_X0)) && (x <= 11'(WIN_X1)) &&
                      (y >= 10'(WIN_Y0)) && (y <= 10'(WIN_Y1));

  // Segment start comes from the final target of the column just left; no segment
  // before the first full column after reset, nor entering at the left window edge.
  always_comb begin
    prev_valid_d = prev_valid_q;
    if (col_change) begin
      prev_valid_d = seen_q;
    end
    if (x == 11'(WIN_X0)) begin
      prev_valid_d = 1'b0;
    end
    for (int i = 0; i < NCH; i++) begin
      ndata[i]    = H'(data[i*DATA_W +: DATA_W] >> v_scaling[i*2 +: 2]);
      cur_t[i]    = ~ndata[i] + H'(offset_q[i]);
      prev_t_d[i] = col_change ? cur_t_q[i] : prev_t_q[i];
      seg_lo[i]   = (prev_t_d[i] < cur_t[i]) ? prev_t_d[i] : cur_t[i];
      seg_hi[i]   = (prev_t_d[i] < cur_t[i]) ? cur_t[i] : prev_t_d[i];
    end
  end

  always_comb begin
    hit = '0;
    for (int i = 0; i < NCH; i++) begin
      if (vector_mode && prev_valid_d) begin
        hit[i] = in_win && ch_en[i] && (y_ext >= seg_lo[i]) && (y_ext <= seg_hi[i]);
      end else begin
        hit[i] = in_win && ch_en[i] && (y_ext == cur_t[i]);
      end
    end
  end

  // Once-per-refresh nudge of the selected channel's offset; out-of-range selects are ignored.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      offset_d[i] = offset_q[i];
      if (refresh && (sel_ch == SEL_W'(i))) begin
        if (up && !down) begin
          offset_d[i] = offset_q[i] - 11'd1;
        end else if (down && !up) begin
          offset_d[i] = offset_q[i] + 11'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        offset_q[i] <= OW'(i * OFFS_STEP);
        cur_t_q[i]  <= '0;
        prev_t_q[i] <= '0;
      end
      x_q           <= '0;
      prev_valid_q  <= 1'b0;
      seen_q        <= 1'b0;
      waveform_on_q <= '0;
      any_on_q      <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        offset_q[i] <= offset_d[i];
        cur_t_q[i]  <= cur_t[i];
        prev_t_q[i] <= prev_t_d[i];
      end
      x_q           <= x;
      prev_valid_q  <= prev_valid_d;
      seen_q        <= 1'b1;
      waveform_on_q <= hit;
      any_on_q      <= |hit;
    end
  end

  assign waveform_on = waveform_on_q;
  assign any_on      = any_on_q;

endmodule

// File: tb/tb_waveform_display_mc.sv
// Scoreboard bench for waveform_display_mc: random and directed pixels, checked against
// a column-level reference model of trace targets, segments and offsets.
module tb_waveform_display_mc;

  localparam int NCH    = 2;
  localparam int WX0    = 20;
  localparam int WX1    = 770;
  localparam int WY0    = 20;
  localparam int WY1    = 620;
  localparam int REFY   = 770;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] data;
  logic [3:0]  v_scaling;
  logic [1:0]  ch_en;
  logic [0:0]  sel_ch;
  logic        up, down, vector_mode;
  logic [10:0] x;
  logic [9:0]  y;
  logic [1:0]  waveform_on;
  logic        any_on;

  waveform_display_mc dut (
    .clk(clk), .reset(reset), .data(data), .v_scaling(v_scaling), .ch_en(ch_en),
    .sel_ch(sel_ch), .up(up), .down(down), .vector_mode(vector_mode), .x(x), .y(y),
    .waveform_on(waveform_on), .any_on(any_on)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] won;
    logic       any;
    string      tag;
  } exp_t;

  exp_t expQ[$];
  int checks = 0;
  int passed = 0;

  // Reference model state, kept per column rather than per register.
  int mOff[NCH];
  int mLastX;
  int mLastT[NCH];
  int mSegT[NCH];
  bit mSegValid;
  int mCycles;

  function automatic void modelReset();
    for (int i = 0; i < NCH; i++) begin
      mOff[i]   = i * 150;
      mLastT[i] = 0;
      mSegT[i]  = 0;
    end
    mLastX    = 0;
    mSegValid = 0;
    mCycles   = 0;
  endfunction

  function automatic int modelTarget(int ch, int d, int vs);
    return (8191 - (d >> vs) + mOff[ch]) % 8192;
  endfunction

  function automatic void checkOutput(exp_t e);
    checks++;
    if (waveform_on === e.won && any_on === e.any) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got waveform_on=%b any_on=%b, expected waveform_on=%b any_on=%b",
               e.tag, waveform_on, any_on, e.won, e.any);
    end
  endfunction

  task automatic applyStimulus(input int xi, input int yi, input int d0, input int d1,
                               input int vs0, input int vs1, input int en, input int sel,
                               input int u, input int dn, input int vm, input string tag);
    exp_t e;
    int   t[NCH];
    int   d[NCH];
    int   vs[NCH];
    int   lo, hi;
    bit   inWin, h;
    @(negedge clk);
    x           = 11'(xi);
    y           = 10'(yi);
    data        = {12'(d1), 12'(d0)};
    v_scaling   = {2'(vs1), 2'(vs0)};
    ch_en       = 2'(en);
    sel_ch      = 1'(sel);
    up          = u[0];
    down        = dn[0];
    vector_mode = vm[0];
    d[0] = d0; d[1] = d1; vs[0] = vs0; vs[1] = vs1;
    for (int i = 0; i < NCH; i++) t[i] = modelTarget(i, d[i], vs[i]);
    // Entering a new column: the segment spans from the previous column's final target.
    if (xi != mLastX && mCycles > 0) begin
      for (int i = 0; i < NCH; i++) mSegT[i] = mLastT[i];
      mSegValid = 1;
    end
    if (xi == WX0) mSegValid = 0;
    inWin = (xi >= WX0) && (xi <= WX1) && (yi >= WY0) && (yi <= WY1);
    e.won = '0;
    for (int i = 0; i < NCH; i++) begin
      if (vm != 0 && mSegValid) begin
        lo = (mSegT[i] < t[i]) ? mSegT[i] : t[i];
        hi = (mSegT[i] < t[i]) ? t[i] : mSegT[i];
        h  = (yi >= lo) && (yi <= hi);
      end else begin
        h  = (yi == t[i]);
      end
      e.won[i] = inWin && ((en >> i) & 1) != 0 && h;
    end
    e.any = |e.won;
    e.tag = tag;
    expQ.push_back(e);
    mLastX = xi;
    for (int i = 0; i < NCH; i++) mLastT[i] = t[i];
    mCycles++;
    if (xi == 0 && yi == REFY && sel < NCH) begin
      if (u != 0 && dn == 0) mOff[sel] = (mOff[sel] + 2047) % 2048;
      else if (dn != 0 && u == 0) mOff[sel] = (mOff[sel] + 1) % 2048;
    end
  endtask

  // Monitor: one registered response per driven cycle, compared after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!reset && expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput(e);
    end
  end

  initial begin
    exp_t z;
    int ylist[8];
    int cx, t0, t1, y0, r, lo, hi, tmp;
    int d0, d1, vs0, vs1, en, vm, sel, u, dn, hold;

    reset = 1'b1; data = '0; v_scaling = '0; ch_en = '0; sel_ch = '0;
    up = 1'b0; down = 1'b0; vector_mode = 1'b0; x = '0; y = '0;
    modelReset();
    repeat (3) @(negedge clk);
    #1;
    z.won = 2'b00; z.any = 1'b0; z.tag = "reset_state";
    checkOutput(z);
    @(negedge clk);
    reset = 1'b0;

    // Channel 0 target wraps off-screen with zero offset; channel 1 sits at row 149.
    ylist = '{20, 100, 149, 300, 500, 620, 19, 621};
    foreach (ylist[k]) applyStimulus(100, ylist[k], 100, 0, 0, 0, 3, 0, 0, 0, 0, "offscreen_wrap");

    repeat (200) applyStimulus(0, REFY, 100, 0, 0, 0, 3, 0, 0, 1, 0, "refresh_down");
    repeat (5)   applyStimulus(0, REFY, 100, 0, 0, 0, 3, 0, 1, 1, 0, "refresh_both");
    applyStimulus(0, REFY, 100, 0, 0, 0, 3, 1, 0, 1, 0, "refresh_ch1");
    applyStimulus(100, 150, 49, 51, 0, 0, 3, 0, 0, 0, 0, "dot_hit_ch0");
    applyStimulus(100, 149, 49, 51, 0, 0, 3, 0, 0, 0, 0, "dot_miss_ch0");
    applyStimulus(101, 99,  49, 51, 0, 0, 3, 0, 0, 0, 0, "dot_hit_ch1");
    applyStimulus(102, 99,  49, 51, 0, 0, 1, 0, 0, 0, 0, "ch1_disabled");

    repeat (500) applyStimulus(0, REFY, 0, 0, 0, 0, 3, 0, 0, 1, 0, "refresh_raise");

    // Vector segment from row 300 (col 101) to row 310 (col 102).
    applyStimulus(101, 300, 399, 0, 0, 0, 1, 0, 0, 0, 1, "vec_col101");
    ylist = '{299, 300, 305, 310, 311, 308, 301, 400};
    foreach (ylist[k]) applyStimulus(102, ylist[k], 389, 0, 0, 0, 1, 0, 0, 0, 1, "vec_col102");
    applyStimulus(19, 300, 399, 0, 0, 0, 1, 0, 0, 0, 1, "vec_pre_edge");
    applyStimulus(20, 305, 389, 0, 0, 0, 1, 0, 0, 0, 1, "vec_edge_mid");
    applyStimulus(20, 310, 389, 0, 0, 0, 1, 0, 0, 0, 1, "vec_edge_dot");
    applyStimulus(21, 305, 399, 0, 0, 0, 1, 0, 0, 0, 1, "vec_after_edge");

    // Scaling and window edges.
    applyStimulus(400, 599, 800, 0, 3, 0, 3, 0, 0, 0, 0, "scale_hit");
    applyStimulus(19,  599, 800, 0, 3, 0, 3, 0, 0, 0, 0, "scale_left_out");
    applyStimulus(771, 599, 800, 0, 3, 0, 3, 0, 0, 0, 0, "scale_right_out");
    applyStimulus(770, 599, 800, 0, 3, 0, 3, 0, 0, 0, 0, "scale_right_in");
    applyStimulus(401, 599, 800, 0, 3, 0, 2, 0, 0, 0, 0, "scale_ch0_off");

    cx = 18;
    for (int c = 0; c < 1500; c++) begin
      d0   = $urandom_range(0, 800);
      d1   = $urandom_range(0, 160);
      vs0  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 0;
      vs1  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 0;
      en   = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : 3;
      vm   = $urandom_range(0, 1);
      sel  = $urandom_range(0, 1);
      u    = $urandom_range(0, 1);
      dn   = $urandom_range(0, 1);
      hold = $urandom_range(1, 3);
      if (cx > 775) begin
        applyStimulus(0, REFY, d0, d1, vs0, vs1, en, sel, u, dn, vm, "rand_refresh");
        cx = 18;
        continue;
      end
      for (int h = 0; h < hold; h++) begin
        t0 = modelTarget(0, d0, vs0);
        t1 = modelTarget(1, d1, vs1);
        r  = $urandom_range(0, 3);
        tmp = $urandom_range(0, 16);
        case (r)
          0: y0 = $urandom_range(0, 1023);
          1: y0 = t0 + tmp - 8;
          2: y0 = t1 + tmp - 8;
          default: begin
            lo = (mLastT[0] < t0) ? mLastT[0] : t0;
            hi = (mLastT[0] < t0) ? t0 : mLastT[0];
            if (hi > 1023) hi = 1023;
            if (lo > hi) lo = hi;
            y0 = $urandom_range(lo, hi);
          end
        endcase
        if (y0 < 0) y0 = 0;
        if (y0 > 1023) y0 = 1023;
        applyStimulus(cx, y0, d0, d1, vs0, vs1, en, 0, 0, 0, vm, "rand");
      end
      cx = cx + $urandom_range(1, 3);
    end

    // Reset in the middle of a line while channel 0 is lit.
    d0 = (8191 + mOff[0] - 400) % 8192;
    applyStimulus(300, 400, d0, 0, 0, 0, 3, 0, 0, 0, 0, "pre_reset_hit");
    @(posedge clk);
    #3;
    z.won = 2'b01; z.any = 1'b1; z.tag = "pre_reset_level";
    checkOutput(z);
    reset = 1'b1;
    #1;
    z.won = 2'b00; z.any = 1'b0; z.tag = "reset_async_drop";
    checkOutput(z);
    expQ.delete();
    modelReset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    applyStimulus(200, 50,  0, 49, 0, 0, 3, 0, 0, 0, 1, "post_reset_dot_only");
    applyStimulus(200, 100, 0, 49, 0, 0, 3, 0, 0, 0, 1, "post_reset_ch1_offset");
    applyStimulus(201, 400, d0, 49, 0, 0, 3, 0, 0, 0, 1, "post_reset_ch0_offset");
    applyStimulus(202, 100, 0, 49, 0, 0, 3, 0, 0, 0, 0, "post_reset_dot");

    repeat (3) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
